// File: rtl/dgd_pkg.sv
// Shared constants and FSM state type for the dual grant decoder.
package dgd_pkg;

    localparam int unsigned N_REQ  = 12;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] NO_REQ = '0;

    typedef enum logic [1:0] {
        StIdle,
        StGnt1,
        StGnt2,
        StFin
    } state_e;

endpackage

// File: rtl/onehot_dec12.sv
// Combinational 4-bit code to 12-bit one-hot decoder; codes 0 and 13..15 give zero.
module onehot_dec12
    import dgd_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [N_REQ-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            onehot_o[i] = (code_i == CODE_W'(i + 1));
        end
    end

endmodule

// File: rtl/dual_grant_decoder.sv
// Accepts a prioritised pair of request codes and grants each in turn, one-hot, until acked.
// Optional grant watchdog enabled by defining DGD_TIMEOUT_EN.
module dual_grant_decoder
    import dgd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] first,
    input  logic [CODE_W-1:0] second,
    output logic [N_REQ-1:0]  gnt,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   g1_q, g1_d;
    logic [N_REQ-1:0]   g2_q, g2_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   g1_in, g2_raw, g2_in;
    logic               in_grant;
    logic               expire;
    logic               advance;

    onehot_dec12 u_dec_first (
        .code_i   (first),
        .onehot_o (g1_in)
    );

    onehot_dec12 u_dec_second (
        .code_i   (second),
        .onehot_o (g2_raw)
    );

    // A repeated code is only granted once.
    assign g2_in    = ((first == second) && (first != NO_REQ)) ? '0 : g2_raw;
    assign in_grant = (state_q == StGnt1) || (state_q == StGnt2);
    assign advance  = ack || expire;

    always_comb begin
        state_d = state_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (code_valid) begin
                    g1_d = g1_in;
                    g2_d = g2_in;
                    if (g1_in != '0) begin
                        state_d = StGnt1;
                        gnt_d   = g1_in;
                    end else if (g2_in != '0) begin
                        state_d = StGnt2;
                        gnt_d   = g2_in;
                    end else begin
                        state_d = StFin;
                        gnt_d   = '0;
                    end
                end
            end
            StGnt1: begin
                if (advance) begin
                    if (g2_q != '0) begin
                        state_d = StGnt2;
                        gnt_d   = g2_q;
                    end else begin
                        state_d = StFin;
                        gnt_d   = '0;
                    end
                end
            end
            StGnt2: begin
                if (advance) begin
                    state_d = StFin;
                    gnt_d   = '0;
                end
            end
            StFin: begin
                state_d = StIdle;
                g1_d    = '0;
                g2_d    = '0;
                gnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            g1_q    <= '0;
            g2_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef DGD_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Count reaching TIMEOUT-1 on an un-acked cycle means TIMEOUT grant cycles have elapsed.
    assign expire = in_grant && !ack && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | expire;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_grant && !ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [7:0] unused_timeout;
    logic       unused_in_grant;

    assign unused_timeout  = 8'(TIMEOUT);
    assign unused_in_grant = in_grant;
    assign expire          = 1'b0;
    assign err             = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFin);
    assign code_ready = (state_q == StIdle);

endmodule

// File: tb/tb_dual_grant_decoder.sv
// Directed scoreboard bench for dual_grant_decoder; covers the watchdog when DGD_TIMEOUT_EN is set.
module tb_dual_grant_decoder;

`ifdef DGD_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    typedef struct packed {
        logic [11:0] gnt;
        logic        busy;
        logic        done;
        logic        ready;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [3:0]  first = '0;
    logic [3:0]  second = '0;
    logic [11:0] gnt;
    logic        ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int   total = 0;
    int   bad = 0;
    logic exp_err = 1'b0;
    exp_t sb[$];

    dual_grant_decoder #(
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .first      (first),
        .second     (second),
        .gnt        (gnt),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".gnt"},   gnt,             e.gnt);
        chk({tag, ".busy"},  12'(busy),       12'(e.busy));
        chk({tag, ".done"},  12'(done),       12'(e.done));
        chk({tag, ".ready"}, 12'(code_ready), 12'(e.ready));
        chk({tag, ".err"},   12'(err),        12'(e.err));
        chk({tag, ".onehot"}, 12'($countones(gnt) <= 1), 12'd1);
    endtask

    // Push expectation, drive one cycle of stimulus, then pop and compare after the edge.
    task automatic tick(input string tag, input logic v, input logic [3:0] f, input logic [3:0] s,
                        input logic a, input logic [11:0] eg, input logic eb, input logic ed,
                        input logic er);
        exp_t e;
        e = '{gnt: eg, busy: eb, done: ed, ready: er, err: exp_err};
        sb.push_back(e);
        code_valid = v;
        first      = f;
        second     = s;
        ack        = a;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.sb: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
        code_valid = 1'b0;
        ack        = 1'b0;
    endtask

    initial begin
        exp_t e;
        // Reset state, with the clock running.
        #2;
        e = '{gnt: 12'h000, busy: 1'b0, done: 1'b0, ready: 1'b1, err: 1'b0};
        check_outputs("reset", e);
        @(posedge clk);
        #1;
        check_outputs("reset_clk", e);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // first=12, second=3, ack on the 3rd cycle of each grant.
        tick("p12_3.xfer", 1'b1, 4'd12, 4'd3, 1'b0, 12'h800, 1'b1, 1'b0, 1'b0);
        tick("p12_3.g1c2", 1'b0, 4'd0,  4'd0, 1'b0, 12'h800, 1'b1, 1'b0, 1'b0);
        tick("p12_3.g1c3", 1'b0, 4'd0,  4'd0, 1'b0, 12'h800, 1'b1, 1'b0, 1'b0);
        tick("p12_3.ack1", 1'b0, 4'd0,  4'd0, 1'b1, 12'h004, 1'b1, 1'b0, 1'b0);
        tick("p12_3.g2c2", 1'b0, 4'd0,  4'd0, 1'b0, 12'h004, 1'b1, 1'b0, 1'b0);
        tick("p12_3.g2c3", 1'b0, 4'd0,  4'd0, 1'b0, 12'h004, 1'b1, 1'b0, 1'b0);
        tick("p12_3.ack2", 1'b0, 4'd0,  4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p12_3.idle", 1'b0, 4'd0,  4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

        // Equal codes: single grant only.
        tick("p5_5.xfer", 1'b1, 4'd5, 4'd5, 1'b0, 12'h010, 1'b1, 1'b0, 1'b0);
        tick("p5_5.ack",  1'b0, 4'd0, 4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p5_5.idle", 1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

        // No valid code: straight to done; ack ignored in FIN and IDLE.
        tick("p0_14.xfer", 1'b1, 4'd0, 4'd14, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p0_14.idle", 1'b0, 4'd0, 4'd0,  1'b1, 12'h000, 1'b0, 1'b0, 1'b1);
        tick("p0_14.stay", 1'b0, 4'd3, 4'd4,  1'b1, 12'h000, 1'b0, 1'b0, 1'b1);

        // Invalid first code falls through to the second grant.
        tick("p13_4.xfer", 1'b1, 4'd13, 4'd4, 1'b0, 12'h008, 1'b1, 1'b0, 1'b0);
        tick("p13_4.ack",  1'b0, 4'd0,  4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p13_4.idle", 1'b0, 4'd0,  4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

        // ack held high throughout: one state per cycle.
        tick("p2_9.xfer", 1'b1, 4'd2, 4'd9, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
        tick("p2_9.g2",   1'b0, 4'd0, 4'd0, 1'b1, 12'h100, 1'b1, 1'b0, 1'b0);
        tick("p2_9.fin",  1'b0, 4'd0, 4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p2_9.idle", 1'b0, 4'd0, 4'd0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1);

        // Reset mid-grant drops gnt asynchronously and discards the pair.
        tick("p1_2.xfer", 1'b1, 4'd1, 4'd2, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        e = '{gnt: 12'h000, busy: 1'b0, done: 1'b0, ready: 1'b1, err: 1'b0};
        exp_err = 1'b0;
        check_outputs("async_rst", e);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", e);
        tick("p6_0.xfer", 1'b1, 4'd6, 4'd0, 1'b0, 12'h020, 1'b1, 1'b0, 1'b0);
        tick("p6_0.ack",  1'b0, 4'd0, 4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("p6_0.idle", 1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

`ifdef DGD_TIMEOUT_EN
        // Watchdog: grant held TO cycles, then err set and done pulses.
        tick("to.xfer", 1'b1, 4'd7, 4'd0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < int'(TO); i++) begin
            tick("to.hold", 1'b0, 4'd0, 4'd0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0);
        end
        exp_err = 1'b1;
        tick("to.fin",  1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("to.idle", 1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        tick("to.stky", 1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
`else
        // Without the watchdog a grant waits for ack indefinitely.
        tick("wait.xfer", 1'b1, 4'd7, 4'd0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick("wait.hold", 1'b0, 4'd0, 4'd0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0);
        end
        tick("wait.ack",  1'b0, 4'd0, 4'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0);
        tick("wait.idle", 1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
